xxhash32_driver: RTL and testbench

Stream-side initiator for the `xxhash32` core. It accepts a message as a seed plus a word count and a valid/ready word stream, and sequences the core's `seed_in` / `add_to_hash` / `request_hash` controls. It captures `output_hash` on `hash_ready` and presents the digest through a valid/ready result port. It sits between any word-producing source (DMA, UART unpacker, test driver) and one `xxhash32` instance.

---
 rtl/xxhash32_driver_if.sv | 44 ++++
 rtl/xxhash32_driver.sv | 126 ++++++++++++
 tb/tb_xxhash32_driver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xxhash32_driver_if.sv
// Bundled control, stream, core and result signals of the xxhash32 driver.
// master is the driver's view; slave is the surrounding system's view.
interface xxhash32_driver_if #(
  parameter int WORD_SIZE   = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic [WORD_SIZE-1:0]   seed;
  logic [COUNT_WIDTH-1:0] msg_words;
  logic                   busy;
  logic                   s_valid;
  logic                   s_ready;
  logic [WORD_SIZE-1:0]   s_data;
  logic                   add_to_hash;
  logic                   request_hash;
  logic                   seed_in;
  logic [WORD_SIZE-1:0]   input_bytes;
  logic                   hash_ready;
  logic [WORD_SIZE-1:0]   output_hash;
  logic                   res_valid;
  logic                   res_ready;
  logic [WORD_SIZE-1:0]   res_hash;
  logic                   res_err;

  modport master (
    input  start, seed, msg_words,
    input  s_valid, s_data,
    input  hash_ready, output_hash,
    input  res_ready,
    output busy, s_ready,
    output add_to_hash, request_hash, seed_in, input_bytes,
    output res_valid, res_hash, res_err
  );

  modport slave (
    output start, seed, msg_words,
    output s_valid, s_data,
    output hash_ready, output_hash,
    output res_ready,
    input  busy, s_ready,
    input  add_to_hash, request_hash, seed_in, input_bytes,
    input  res_valid, res_hash, res_err
  );
endinterface

// File: rtl/xxhash32_driver.sv
// Sequences an xxhash32 core: seed, stream words, request, return digest.
// Optional REQ watchdog enabled by XXHASH32_DRIVER_TIMEOUT_EN.
module xxhash32_driver #(
  parameter int WORD_SIZE      = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            rst,
  xxhash32_driver_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, SEED, FEED, REQ, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   seed_q, seed_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [WORD_SIZE-1:0]   hash_q, hash_d;

`ifdef XXHASH32_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tmo_hit;
  assign tmo_hit     = (tmo_q == TMO_LAST);
  assign tmo_d       = (state_q == REQ) ? tmo_q + 1'b1 : '0;
  assign bus.res_err = err_q;
`else
  logic          tmo_hit;
  wire           unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit     = 1'b0;
  assign bus.res_err = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    seed_d           = seed_q;
    rem_d            = rem_q;
    hash_d           = hash_q;
`ifdef XXHASH32_DRIVER_TIMEOUT_EN
    err_d            = err_q;
`endif
    bus.s_ready      = 1'b0;
    bus.seed_in      = 1'b0;
    bus.add_to_hash  = 1'b0;
    bus.request_hash = 1'b0;
    bus.input_bytes  = '0;
    bus.res_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          seed_d  = bus.seed;
          rem_d   = bus.msg_words;
          state_d = SEED;
        end
      end
      SEED: begin
        bus.seed_in     = 1'b1;
        bus.input_bytes = seed_q;
        state_d         = (rem_q != '0) ? FEED : REQ;
      end
      FEED: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          bus.add_to_hash = 1'b1;
          bus.input_bytes = bus.s_data;
          rem_d           = rem_q - 1'b1;
          if (rem_q == COUNT_WIDTH'(1)) state_d = REQ;
        end
      end
      REQ: begin
        bus.request_hash = 1'b1;
        if (bus.hash_ready) begin
          hash_d  = bus.output_hash;
`ifdef XXHASH32_DRIVER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = DONE;
        end else if (tmo_hit) begin
          // Watchdog abort: digest is meaningless, flag it
          hash_d  = '0;
`ifdef XXHASH32_DRIVER_TIMEOUT_EN
          err_d   = 1'b1;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.res_hash = hash_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      seed_q  <= '0;
      rem_q   <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      rem_q   <= rem_d;
      hash_q  <= hash_d;
    end
  end

`ifdef XXHASH32_DRIVER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`endif
endmodule

// File: tb/tb_xxhash32_driver.sv
// Directed bench for xxhash32_driver with a behavioural xxhash32 core.
// Timeout case is built only when XXHASH32_DRIVER_TIMEOUT_EN is defined.
module tb_xxhash32_driver;
  localparam logic [31:0] P1 = 32'h9E3779B1;
  localparam logic [31:0] P2 = 32'h85EBCA77;
  localparam logic [31:0] P3 = 32'hC2B2AE3D;
  localparam logic [31:0] P4 = 32'h27D4EB2F;
  localparam logic [31:0] P5 = 32'h165667B1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xxhash32_driver_if #(.WORD_SIZE(32), .COUNT_WIDTH(16)) bus ();

  xxhash32_driver #(
    .WORD_SIZE(32), .COUNT_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errs = 0;
  int checks = 0;
  int extra = 0;
  int ctl_viol = 0;
  int seeds = 0;
  int nwords = 0;
  bit stuck = 1'b0;
  logic [31:0] msg [0:63];
  logic [31:0] words [0:63];
  logic [31:0] cseed = '0;
  logic hr_q = 1'b0;
  logic [31:0] oh_q = '0;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] rnd(input logic [31:0] acc, input logic [31:0] in);
    logic [31:0] a;
    a = acc + in * P2;
    a = rotl(a, 13);
    return a * P1;
  endfunction

  // Reference XXH32 over n little-endian 32-bit words
  function automatic logic [31:0] xxh32(input logic [31:0] sd,
                                        input logic [31:0] w [0:63],
                                        input int n);
    logic [31:0] v1, v2, v3, v4, h;
    int i;
    i = 0;
    if (n >= 4) begin
      v1 = sd + P1 + P2; v2 = sd + P2; v3 = sd; v4 = sd - P1;
      while (i + 4 <= n) begin
        v1 = rnd(v1, w[i]);   v2 = rnd(v2, w[i+1]);
        v3 = rnd(v3, w[i+2]); v4 = rnd(v4, w[i+3]);
        i += 4;
      end
      h = rotl(v1, 1) + rotl(v2, 7) + rotl(v3, 12) + rotl(v4, 18);
    end else begin
      h = sd + P5;
    end
    h = h + 32'(4 * n);
    while (i < n) begin
      h = h + w[i] * P3;
      h = rotl(h, 17) * P4;
      i++;
    end
    h = h ^ (h >> 15); h = h * P2;
    h = h ^ (h >> 13); h = h * P3;
    h = h ^ (h >> 16);
    return h;
  endfunction

  // Core model: no reset, 2-cycle response to request_hash
  always @(posedge clk) begin
    if (bus.seed_in) begin
      cseed  <= bus.input_bytes;
      nwords <= 0;
      seeds  <= seeds + 1;
    end else if (bus.add_to_hash) begin
      words[nwords] <= bus.input_bytes;
      nwords <= nwords + 1;
    end
    hr_q <= bus.request_hash && !hr_q && !stuck;
    if (bus.request_hash && !hr_q) oh_q <= xxh32(cseed, words, nwords);
  end
  assign bus.hash_ready  = hr_q;
  assign bus.output_hash = oh_q;

  always @(negedge clk) begin
    if (!rst) begin
      if (32'(bus.seed_in) + 32'(bus.add_to_hash) + 32'(bus.request_hash) > 1)
        ctl_viol++;
      if (!bus.seed_in && !bus.add_to_hash && bus.input_bytes != 0)
        ctl_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_add"}, 32'(bus.add_to_hash), 0);
    chk({tag, "_req"}, 32'(bus.request_hash), 0);
    chk({tag, "_seed_in"}, 32'(bus.seed_in), 0);
    chk({tag, "_in_bytes"}, bus.input_bytes, 0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_res_hash"}, bus.res_hash, 0);
    chk({tag, "_res_err"}, 32'(bus.res_err), 0);
  endtask

  task automatic send(input logic [31:0] sd, input int n, input bit gappy,
                      output int lat);
    int k, cyc;
    k = 0; cyc = 0; lat = -1;
    bus.seed = sd; bus.msg_words = 16'(n); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (bus.res_valid) begin
        lat = cyc;
        break;
      end
      bus.s_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = (k < n) ? msg[k] : 32'hBAD0_0000 + 32'(k);
      #1;
      if (bus.s_valid && bus.s_ready) begin
        if (k >= n) extra++;
        k++;
      end
      tick();
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    if (lat < 0) chk("res_valid_wait", 0, 1);
  endtask

  task automatic consume(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
    chk({tag, "_idle_valid"}, 32'(bus.res_valid), 0);
  endtask

  task automatic run_case(input string tag, input logic [31:0] sd,
                          input int n, input bit gappy);
    int lat;
    send(sd, n, gappy, lat);
    chk({tag, "_hash"}, bus.res_hash, xxh32(sd, msg, n));
    chk({tag, "_err"}, 32'(bus.res_err), 0);
    chk({tag, "_adds"}, nwords, n);
    chk({tag, "_s_ready_done"}, 32'(bus.s_ready), 0);
    if (!gappy) chk({tag, "_latency"}, lat, n + 4);
    consume(tag);
  endtask

  initial begin
    int lat, sb;
    logic [31:0] h;
    bus.start = 0; bus.seed = 0; bus.msg_words = 0;
    bus.s_valid = 0; bus.s_data = 0; bus.res_ready = 0;
    for (int i = 0; i < 64; i++) msg[i] = '0;
    tick(); tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();

    // Empty message, known digest of XXH32("", 0)
    send(32'h0, 0, 1'b0, lat);
    chk("empty_hash", bus.res_hash, 32'h02CC5D05);
    chk("empty_err", 32'(bus.res_err), 0);
    chk("empty_adds", nwords, 0);
    chk("empty_latency", lat, 4);
    consume("empty");

    msg[0] = 32'h0;
    run_case("w1", 32'h0, 1, 1'b0);

    for (int i = 0; i < 4; i++) msg[i] = 32'h01020304 + 32'h04040404 * 32'(i);
    run_case("w4", 32'h12345678, 4, 1'b0);
    run_case("w4g", 32'h12345678, 4, 1'b1);

    for (int i = 0; i < 7; i++) msg[i] = 32'h11111111 * 32'(i + 1);
    run_case("w7", 32'hDEADBEEF, 7, 1'b0);
    run_case("w7g", 32'hDEADBEEF, 7, 1'b1);

    for (int i = 0; i < 9; i++) msg[i] = $urandom;
    run_case("w9", 32'h1, 9, 1'b0);
    run_case("w9g", 32'h1, 9, 1'b1);

    // Hold result with res_ready low; a start pulse here must be ignored
    msg[0] = 32'hCAFEF00D; msg[1] = 32'h0BADC0DE;
    send(32'h55, 2, 1'b0, lat);
    h  = xxh32(32'h55, msg, 2);
    sb = seeds;
    for (int i = 0; i < 10; i++) begin
      chk("hold_hash", bus.res_hash, h);
      chk("hold_busy", 32'(bus.busy), 1);
      bus.start = (i == 3);
      tick();
    end
    bus.start = 1'b0;
    consume("hold");
    tick(); tick();
    chk("hold_no_restart", seeds, sb);
    chk("hold_still_idle", 32'(bus.busy), 0);

    // Reset in FEED after 3 of 8 words
    for (int i = 0; i < 8; i++) msg[i] = 32'hA5A50000 + 32'(i);
    bus.seed = 32'h77; bus.msg_words = 16'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = msg[(i == 0) ? 0 : i - 1];
      tick();
    end
    bus.s_data = msg[3];
    #1;
    chk("mid_pre_add", 32'(bus.add_to_hash), 1);
    chk("mid_pre_count", nwords, 3);
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    tick();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    tick();
    msg[0] = 32'h0;
    run_case("post_rst", 32'h0, 1, 1'b0);

`ifdef XXHASH32_DRIVER_TIMEOUT_EN
    stuck = 1'b1;
    msg[0] = 32'h1; msg[1] = 32'h2;
    send(32'h9, 2, 1'b0, lat);
    chk("tmo_latency", lat, 2 + 2 + 16);
    chk("tmo_valid", 32'(bus.res_valid), 1);
    chk("tmo_err", 32'(bus.res_err), 1);
    chk("tmo_hash", bus.res_hash, 0);
    consume("tmo");
    stuck = 1'b0;
`endif

    chk("extra_words", extra, 0);
    chk("ctl_onehot_zero", ctl_viol, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
